red_pitaya_sort_pulser: RTL and testbench

Consumer end of the FADS sort trigger. It turns each rising edge of the sort trigger into a bipolar square-wave burst of programmable amplitude, period and cycle count. The burst is driven as 14-bit signed DAC codes toward the external high-voltage amplifier. The block sits between the FADS detector output and the DAC path, and is configured and monitored over the standard system bus.

---
 rtl/red_pitaya_sort_pulser.sv | 188 ++++++++++++++++++
 tb/tb_red_pitaya_sort_pulser.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/red_pitaya_sort_pulser.sv
// Sort-trigger pulser: each rising edge of sort_trig_i emits a bipolar square burst on dac_o.
// Build option SORT_PULSER_SW_TRIG_EN adds a software trigger register at 0x2C.
module red_pitaya_sort_pulser #(
  parameter int DW  = 14,
  parameter int MEM = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rstn_i,
  input  logic          sort_trig_i,
  output logic [DW-1:0] dac_o,
  output logic          busy_o,
  input  logic [31:0]   sys_addr,
  input  logic [31:0]   sys_wdata,
  input  logic [3:0]    sys_sel,
  input  logic          sys_wen,
  input  logic          sys_ren,
  output logic [31:0]   sys_rdata,
  output logic          sys_err,
  output logic          sys_ack
);

  typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} state_t;

  localparam logic [MEM-1:0] ONE = MEM'(1);

  logic [19:0]    addr;
  logic           enable_reg;
  logic           abort_reg;
  logic [DW-1:0]  hi_code_reg;
  logic [DW-1:0]  lo_code_reg;
  logic [DW-1:0]  idle_code_reg;
  logic [MEM-1:0] half_period_reg;
  logic [MEM-1:0] n_cycles_reg;

  state_t         state;
  logic           trig_q;
  logic           rise;
  logic [DW-1:0]  sh_hi;
  logic [DW-1:0]  sh_lo;
  logic [MEM-1:0] sh_hp;
  logic [MEM-1:0] sh_n;
  logic [MEM-1:0] phase_cnt;
  logic [MEM-1:0] cyc_cnt;
  logic [MEM-1:0] trig_count;
  logic [MEM-1:0] missed_count;

  logic unused;
  assign unused  = ^{sys_sel, sys_addr[31:20]};
  assign addr    = sys_addr[19:0];
  assign sys_err = 1'b0;

`ifdef SORT_PULSER_SW_TRIG_EN
  logic sw_trig_reg;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) sw_trig_reg <= 1'b0;
    else             sw_trig_reg <= sys_wen && (addr == 20'h2C) && sys_wdata[0];
  end

  assign rise = (sort_trig_i & ~trig_q) | sw_trig_reg;
`else
  assign rise = sort_trig_i & ~trig_q;
`endif

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      sys_ack         <= 1'b0;
      sys_rdata       <= '0;
      enable_reg      <= 1'b0;
      abort_reg       <= 1'b0;
      hi_code_reg     <= {1'b0, {(DW-1){1'b1}}};
      lo_code_reg     <= {1'b1, {(DW-1){1'b0}}};
      idle_code_reg   <= '0;
      half_period_reg <= MEM'(6250);
      n_cycles_reg    <= MEM'(10);
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      abort_reg <= 1'b0;
      if (sys_wen) begin
        case (addr)
          20'h00: begin
            enable_reg <= sys_wdata[0];
            abort_reg  <= sys_wdata[1];
          end
          20'h04:  hi_code_reg     <= sys_wdata[DW-1:0];
          20'h08:  lo_code_reg     <= sys_wdata[DW-1:0];
          20'h0C:  idle_code_reg   <= sys_wdata[DW-1:0];
          20'h10:  half_period_reg <= MEM'(sys_wdata);
          20'h14:  n_cycles_reg    <= MEM'(sys_wdata);
          default: ;
        endcase
      end
      sys_rdata <= '0;
      if (sys_ren) begin
        case (addr)
          20'h00:  sys_rdata <= {31'd0, enable_reg};
          20'h04:  sys_rdata <= {{(32-DW){1'b0}}, hi_code_reg};
          20'h08:  sys_rdata <= {{(32-DW){1'b0}}, lo_code_reg};
          20'h0C:  sys_rdata <= {{(32-DW){1'b0}}, idle_code_reg};
          20'h10:  sys_rdata <= 32'(half_period_reg);
          20'h14:  sys_rdata <= 32'(n_cycles_reg);
          20'h20:  sys_rdata <= 32'(trig_count);
          20'h24:  sys_rdata <= 32'(missed_count);
          20'h28:  sys_rdata <= {28'd0, state, 1'b0, busy_o};
          default: sys_rdata <= '0;
        endcase
      end
    end
  end

  // phase_cnt counts the cycles already spent in the current half; >= makes a zero half-period act as one.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state        <= IDLE;
      dac_o        <= '0;
      busy_o       <= 1'b0;
      trig_q       <= 1'b0;
      sh_hi        <= '0;
      sh_lo        <= '0;
      sh_hp        <= '0;
      sh_n         <= '0;
      phase_cnt    <= '0;
      cyc_cnt      <= '0;
      trig_count   <= '0;
      missed_count <= '0;
    end else begin
      trig_q <= sort_trig_i;
      if (abort_reg) begin
        state  <= IDLE;
        dac_o  <= idle_code_reg;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            dac_o <= idle_code_reg;
            if (rise && enable_reg) begin
              trig_count <= trig_count + ONE;
              if (n_cycles_reg != '0) begin
                sh_hi     <= hi_code_reg;
                sh_lo     <= lo_code_reg;
                sh_hp     <= half_period_reg;
                sh_n      <= n_cycles_reg;
                phase_cnt <= ONE;
                cyc_cnt   <= ONE;
                state     <= HI;
                dac_o     <= hi_code_reg;
                busy_o    <= 1'b1;
              end
            end
          end
          HI: begin
            if (rise) missed_count <= missed_count + ONE;
            if (phase_cnt >= sh_hp) begin
              state     <= LO;
              dac_o     <= sh_lo;
              phase_cnt <= ONE;
            end else begin
              phase_cnt <= phase_cnt + ONE;
            end
          end
          LO: begin
            if (rise) missed_count <= missed_count + ONE;
            if (phase_cnt >= sh_hp) begin
              phase_cnt <= ONE;
              if (cyc_cnt < sh_n) begin
                cyc_cnt <= cyc_cnt + ONE;
                state   <= HI;
                dac_o   <= sh_hi;
              end else begin
                state  <= IDLE;
                dac_o  <= idle_code_reg;
                busy_o <= 1'b0;
              end
            end else begin
              phase_cnt <= phase_cnt + ONE;
            end
          end
          default: begin
            state  <= IDLE;
            dac_o  <= idle_code_reg;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_sort_pulser.sv
// Scoreboard bench for red_pitaya_sort_pulser: a time-offset reference model predicts every output
// cycle and bus read; a negedge monitor pops and compares. Honors SORT_PULSER_SW_TRIG_EN.
module tb_red_pitaya_sort_pulser;
  localparam int DW = 14;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          sort_trig = 1'b0;
  logic [DW-1:0] dac;
  logic          busy;
  logic [31:0]   sys_addr  = '0;
  logic [31:0]   sys_wdata = '0;
  logic [3:0]    sys_sel   = 4'hF;
  logic          sys_wen   = 1'b0;
  logic          sys_ren   = 1'b0;
  logic [31:0]   sys_rdata;
  logic          sys_err;
  logic          sys_ack;

  always #5 clk = ~clk;

  red_pitaya_sort_pulser #(.DW(DW), .MEM(32)) dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rst_n),
    .sort_trig_i(sort_trig),
    .dac_o      (dac),
    .busy_o     (busy),
    .sys_addr   (sys_addr),
    .sys_wdata  (sys_wdata),
    .sys_sel    (sys_sel),
    .sys_wen    (sys_wen),
    .sys_ren    (sys_ren),
    .sys_rdata  (sys_rdata),
    .sys_err    (sys_err),
    .sys_ack    (sys_ack)
  );

  int checks = 0;
  int passed = 0;
  int busy_cycles = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  typedef struct { logic [DW-1:0] dac; logic busy; } out_t;
  typedef struct {
    bit is_read; logic [19:0] addr; logic [31:0] wdata; logic [31:0] exp;
    bit has_plan; logic [31:0] plan;
  } bus_t;

  out_t out_q[$];
  bus_t bus_q[$];
  bit          plan_valid = 1'b0;
  logic [31:0] plan_val   = '0;

  // Reference model state: configuration, counters and the current burst as (start edge, shape).
  bit            m_en, m_abort, m_sw, m_prev, m_active, m_busy;
  logic [DW-1:0] m_hi, m_lo, m_idle, b_hi, b_lo;
  logic [31:0]   m_hp, m_n, m_trig, m_miss;
  logic [1:0]    m_state;
  longint        k = 0, t0 = 0, b_hp = 0, b_n = 0;

  task automatic model_reset();
    m_en = 0; m_abort = 0; m_sw = 0; m_prev = 0; m_active = 0; m_busy = 0;
    m_hi = 14'h1FFF; m_lo = 14'h2000; m_idle = '0;
    m_hp = 32'd6250; m_n = 32'd10; m_trig = '0; m_miss = '0; m_state = 2'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [19:0] a);
    case (a)
      20'h00:  return {31'd0, m_en};
      20'h04:  return {18'd0, m_hi};
      20'h08:  return {18'd0, m_lo};
      20'h0C:  return {18'd0, m_idle};
      20'h10:  return m_hp;
      20'h14:  return m_n;
      20'h20:  return m_trig;
      20'h24:  return m_miss;
      20'h28:  return {28'd0, m_state, 1'b0, m_busy};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    bit     rise;
    longint total, off;
    out_t   o;
    bus_t   e;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        k++;
        if (sys_wen || sys_ren) begin
          e.is_read = sys_ren; e.addr = sys_addr[19:0]; e.wdata = sys_wdata;
          e.exp = model_read(sys_addr[19:0]); e.has_plan = plan_valid; e.plan = plan_val;
          bus_q.push_back(e);
        end
        rise = sort_trig && !m_prev;
`ifdef SORT_PULSER_SW_TRIG_EN
        rise = rise || m_sw;
`endif
        if (m_abort) begin
          m_active = 0;
        end else if (m_busy) begin
          if (rise) m_miss++;
        end else if (rise && m_en) begin
          m_trig++;
          if (m_n != 0) begin
            m_active = 1; t0 = k; b_hi = m_hi; b_lo = m_lo;
            b_hp = (m_hp == 0) ? 64'd1 : longint'(m_hp);
            b_n  = longint'(m_n);
          end
        end
        total = 2 * b_hp * b_n;
        o.dac = m_idle; o.busy = 0; m_state = 2'd0;
        if (m_active && ((k - t0) < total)) begin
          off = (k - t0) / b_hp;
          if (off % 2 == 0) begin o.dac = b_hi; m_state = 2'd1; end
          else              begin o.dac = b_lo; m_state = 2'd2; end
          o.busy = 1;
        end else begin
          m_active = 0;
        end
        out_q.push_back(o);
        m_busy  = o.busy;
        m_abort = 0;
        m_sw    = 0;
        if (sys_wen) begin
          case (sys_addr[19:0])
            20'h00: begin m_en = sys_wdata[0]; m_abort = sys_wdata[1]; end
            20'h04: m_hi   = sys_wdata[DW-1:0];
            20'h08: m_lo   = sys_wdata[DW-1:0];
            20'h0C: m_idle = sys_wdata[DW-1:0];
            20'h10: m_hp   = sys_wdata;
            20'h14: m_n    = sys_wdata;
            20'h2C: begin
`ifdef SORT_PULSER_SW_TRIG_EN
              m_sw = sys_wdata[0];
`endif
            end
            default: ;
          endcase
        end
        m_prev = sort_trig;
      end
    end
  end

  initial begin
    out_t o;
    bus_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        out_q.delete();
        bus_q.delete();
        chk("reset_dac",   32'(dac), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);
        chk("reset_ack",   32'(sys_ack), 32'd0);
        chk("reset_rdata", sys_rdata, 32'd0);
      end else begin
        if (busy) busy_cycles++;
        if (out_q.size() > 0) begin
          o = out_q.pop_front();
          chk("dac",  32'(dac),  32'(o.dac));
          chk("busy", 32'(busy), 32'(o.busy));
        end
        if (bus_q.size() > 0) begin
          e = bus_q.pop_front();
          chk("ack", 32'(sys_ack), 32'd1);
          chk("err", 32'(sys_err), 32'd0);
          if (e.is_read) begin
            chk($sformatf("rd_0x%02h", e.addr), sys_rdata, e.exp);
            if (e.has_plan) chk($sformatf("plan_rd_0x%02h", e.addr), sys_rdata, e.plan);
            $display("rd addr=0x%02h data=0x%08h model=0x%08h", e.addr, sys_rdata, e.exp);
          end else begin
            $display("wr addr=0x%02h data=0x%08h", e.addr, e.wdata);
          end
        end else begin
          chk("ack_idle", 32'(sys_ack), 32'd0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [19:0] a, input logic [31:0] d);
    sys_addr = {12'd0, a}; sys_wdata = d; sys_wen = 1'b1;
    tick(1);
    sys_wen = 1'b0;
  endtask

  task automatic rd(input logic [19:0] a);
    sys_addr = {12'd0, a}; sys_ren = 1'b1;
    tick(1);
    sys_ren = 1'b0;
  endtask

  task automatic rd_plan(input logic [19:0] a, input logic [31:0] v);
    plan_valid = 1'b1; plan_val = v;
    rd(a);
    plan_valid = 1'b0;
  endtask

  task automatic pulse();
    sort_trig = 1'b1;
    tick(1);
    sort_trig = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cur_en;
    int ncyc;
    int r;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    rd_plan(20'h00, 32'd0);     rd_plan(20'h04, 32'h1FFF); rd_plan(20'h08, 32'h2000);
    rd_plan(20'h0C, 32'd0);     rd_plan(20'h10, 32'd6250); rd_plan(20'h14, 32'd10);
    rd_plan(20'h20, 32'd0);     rd_plan(20'h24, 32'd0);    rd_plan(20'h28, 32'd0);
    rd_plan(20'h2C, 32'd0);     rd_plan(20'h40, 32'd0);

    // basic burst: 4-cycle halves, 2 cycles
    wr(20'h04, 32'h1000); wr(20'h08, 32'h3000); wr(20'h10, 32'd4); wr(20'h14, 32'd2);
    wr(20'h00, 32'd1);
    busy_cycles = 0;
    sort_trig = 1'b1; tick(50); sort_trig = 1'b0; tick(2);
    chk("burst_busy_cycles", 32'(busy_cycles), 32'd16);
    rd_plan(20'h20, 32'd1); rd_plan(20'h24, 32'd0);

    // second rise 6 cycles into a burst
    busy_cycles = 0;
    sort_trig = 1'b1; tick(3); sort_trig = 1'b0; tick(3); sort_trig = 1'b1; tick(30);
    sort_trig = 1'b0; tick(1);
    chk("missed_busy_cycles", 32'(busy_cycles), 32'd16);
    rd_plan(20'h20, 32'd2); rd_plan(20'h24, 32'd1);

    // disabled trigger, then zero cycle count
    wr(20'h0C, 32'h0123); wr(20'h00, 32'd0);
    busy_cycles = 0; pulse(); tick(10);
    chk("disabled_busy_cycles", 32'(busy_cycles), 32'd0);
    rd_plan(20'h20, 32'd2); rd_plan(20'h24, 32'd1);
    wr(20'h14, 32'd0); wr(20'h00, 32'd1);
    busy_cycles = 0; pulse(); tick(10);
    chk("zero_n_busy_cycles", 32'(busy_cycles), 32'd0);
    rd_plan(20'h20, 32'd3);

    // shadowed half_period, live idle_code
    wr(20'h14, 32'd2); wr(20'h10, 32'd4);
    busy_cycles = 0; pulse(); tick(3);
    wr(20'h10, 32'd100); wr(20'h0C, 32'h0055); tick(20);
    chk("shadow_first_busy", 32'(busy_cycles), 32'd16);
    busy_cycles = 0; pulse(); tick(410);
    chk("shadow_second_busy", 32'(busy_cycles), 32'd400);
    rd_plan(20'h20, 32'd5); rd_plan(20'h10, 32'd100);

    // abort during HI with a rise on the abort edge
    wr(20'h10, 32'd10); wr(20'h14, 32'd3);
    pulse(); tick(4);
    wr(20'h00, 32'd3);
    sort_trig = 1'b1; tick(1);
    rd_plan(20'h28, 32'd0); rd_plan(20'h20, 32'd6); rd_plan(20'h24, 32'd1);
    sort_trig = 1'b0; tick(2);

    // software trigger
    wr(20'h10, 32'd4); wr(20'h14, 32'd2);
    busy_cycles = 0; wr(20'h2C, 32'd1); tick(25);
`ifdef SORT_PULSER_SW_TRIG_EN
    chk("sw_trig_busy", 32'(busy_cycles), 32'd16);
    rd_plan(20'h20, 32'd7);
`else
    chk("sw_trig_busy", 32'(busy_cycles), 32'd0);
    rd_plan(20'h20, 32'd6);
`endif
    rd_plan(20'h2C, 32'd0);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      cur_en = ($urandom_range(0, 4) != 0);
      wr(20'h04, 32'($urandom_range(0, 16383)));
      wr(20'h08, 32'($urandom_range(0, 16383)));
      wr(20'h0C, 32'($urandom_range(0, 16383)));
      wr(20'h10, 32'($urandom_range(0, 5)));
      wr(20'h14, 32'($urandom_range(0, 3)));
      wr(20'h00, {31'd0, cur_en});
      ncyc = int'($urandom_range(20, 60));
      for (int c = 0; c < ncyc; c++) begin
        r = int'($urandom_range(0, 39));
        if (r == 0)      wr(20'h00, {30'd0, 1'b1, cur_en});
        else if (r == 1) wr(20'h2C, 32'd1);
        else if (r == 2) wr(20'h10, 32'($urandom_range(1, 5)));
        else begin
          if ($urandom_range(0, 3) == 0) sort_trig = ~sort_trig;
          tick(1);
        end
      end
      rd(20'h20); rd(20'h24); rd(20'h28); rd(20'h00);
    end

    // asynchronous reset in the middle of a burst
    sort_trig = 1'b0;
    wr(20'h10, 32'd4); wr(20'h14, 32'd3); wr(20'h00, 32'd1);
    pulse(); tick(5);
    rst_n = 1'b0;
    #1;
    chk("async_reset_dac",  32'(dac),  32'd0);
    chk("async_reset_busy", 32'(busy), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    rd_plan(20'h04, 32'h1FFF); rd_plan(20'h20, 32'd0); rd_plan(20'h00, 32'd0);

    tick(5);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
